// File: rtl/gray_pkg.sv
// Shared constants and FSM state encoding for the FIFO-to-grey pixel reader.
package gray_pkg;

    localparam int unsigned COEF_R     = 77;
    localparam int unsigned COEF_G     = 150;
    localparam int unsigned COEF_B     = 29;
    localparam int unsigned GRAY_SHIFT = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_READ    = 2'd0;
    localparam state_t ST_CAPTURE = 2'd1;
    localparam state_t ST_CALC    = 2'd2;
    localparam state_t ST_OUT     = 2'd3;

endpackage

// File: rtl/gray_calc.sv
// Weighted RGB-to-grey sum and shift; define GRAY_ROUND_EN for round-half-up instead of truncation.
module gray_calc
    import gray_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] r,
    input  logic [DATA_WIDTH-1:0] g,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] gray_c
);

    localparam int unsigned SUM_W = 2 * DATA_WIDTH;
`ifdef GRAY_ROUND_EN
    localparam int unsigned ROUND_ADD = 1 << (GRAY_SHIFT - 1);
`else
    localparam int unsigned ROUND_ADD = 0;
`endif

    logic [SUM_W-1:0] sum;

    // Coefficients total 256, so the rounded sum still fits SUM_W bits.
    always_comb begin
        sum    = SUM_W'(COEF_R) * SUM_W'(r)
               + SUM_W'(COEF_G) * SUM_W'(g)
               + SUM_W'(COEF_B) * SUM_W'(b)
               + SUM_W'(ROUND_ADD);
        gray_c = DATA_WIDTH'(sum >> GRAY_SHIFT);
    end

endmodule

// File: rtl/fifo_gray_reader.sv
// Reads R,G,B byte triples from a FIFO and emits one grey pixel per triple over a valid/ready port.
// Optional build macro GRAY_ROUND_EN selects rounding in gray_calc.
module fifo_gray_reader
    import gray_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pix_count
);

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            chan;
    logic [1:0]            chan_nxt;
    logic                  rd_c;
    logic                  accept_c;
    logic [DATA_WIDTH-1:0] ch_r;
    logic [DATA_WIDTH-1:0] ch_g;
    logic [DATA_WIDTH-1:0] ch_b;
    logic [DATA_WIDTH-1:0] gray_c;

    gray_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_calc (
        .r      (ch_r),
        .g      (ch_g),
        .b      (ch_b),
        .gray_c (gray_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_READ;
            chan  <= 2'd0;
        end else begin
            state <= state_nxt;
            chan  <= chan_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        chan_nxt  = chan;
        rd_c      = 1'b0;
        accept_c  = 1'b0;
        case (state)
            ST_READ: begin
                if (!fifo_empty) begin
                    rd_c      = 1'b1;
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (chan == 2'd2) begin
                    state_nxt = ST_CALC;
                end else begin
                    chan_nxt  = chan + 2'd1;
                    state_nxt = ST_READ;
                end
            end
            ST_CALC: begin
                state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (pix_ready) begin
                    accept_c  = 1'b1;
                    chan_nxt  = 2'd0;
                    state_nxt = ST_READ;
                end
            end
            default: begin
                chan_nxt  = 2'd0;
                state_nxt = ST_READ;
            end
        endcase
    end

    // Read strobe must be decoded in the READ cycle so data lands during CAPTURE.
    assign fifo_rd = rd_c & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_r      <= '0;
            ch_g      <= '0;
            ch_b      <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            pix_count <= '0;
            busy      <= 1'b0;
        end else begin
            if (state == ST_CAPTURE) begin
                case (chan)
                    2'd0:    ch_r <= fifo_data;
                    2'd1:    ch_g <= fifo_data;
                    default: ch_b <= fifo_data;
                endcase
            end
            if (state == ST_CALC) begin
                pix_data <= gray_c;
            end
            if (accept_c) begin
                pix_count <= pix_count + CNT_WIDTH'(1);
            end
            pix_valid <= (state_nxt == ST_OUT);
            busy      <= !((state_nxt == ST_READ) && (chan_nxt == 2'd0));
        end
    end

endmodule

// File: tb/tb_fifo_gray_reader.sv
// Self-checking bench for fifo_gray_reader: FIFO model, grey reference, latency and handshake checks.
module tb_fifo_gray_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          busy;
    logic [CW-1:0] pix_count;

    always #5 clk = ~clk;

    fifo_gray_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .busy       (busy),
        .pix_count  (pix_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_count = 0;

    logic [7:0] q[$];
    bit         hold_empty = 1'b0;
    int         rd_cycles[$];
    int         vrise[$];
    int         acc_cyc[$];
    logic [7:0] acc_data[$];
    int         rd_empty_viol = 0;
    int         stab_viol = 0;
    bit         prev_vld = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    // Reference grey value straight from the weighting formula.
    function automatic int gray_ref(input int r, input int g, input int b);
`ifdef GRAY_ROUND_EN
        return (77 * r + 150 * g + 29 * b + 128) / 256;
`else
        return (77 * r + 150 * g + 29 * b) / 256;
`endif
    endfunction

    // One clock: record observations before the edge, then model the FIFO read latency.
    task automatic step();
        logic       rd_s;
        logic       vld_s;
        logic       rdy_s;
        logic       emp_s;
        logic       rst_s;
        logic [7:0] d_s;
        fifo_empty = hold_empty || (q.size() == 0);
        #1;
        rd_s  = fifo_rd;
        vld_s = pix_valid;
        rdy_s = pix_ready;
        emp_s = fifo_empty;
        rst_s = rst;
        d_s   = pix_data;
        if (rd_s && emp_s) rd_empty_viol++;
        if (rd_s) rd_cycles.push_back(cyc);
        if (vld_s && !prev_vld) vrise.push_back(cyc);
        if (prev_stall && !(vld_s && d_s == prev_data)) stab_viol++;
        if (vld_s && rdy_s && !rst_s) begin
            acc_data.push_back(d_s);
            acc_cyc.push_back(cyc);
        end
        prev_stall = vld_s && !rdy_s && !rst_s;
        prev_vld   = vld_s;
        prev_data  = d_s;
        @(posedge clk);
        #1;
        if (rd_s && q.size() > 0) fifo_data = q.pop_front();
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_logs();
        rd_cycles.delete();
        vrise.delete();
        acc_cyc.delete();
        acc_data.delete();
        rd_empty_viol = 0;
        stab_viol     = 0;
    endtask

    task automatic drain(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (acc_data.size() >= target) break;
            step();
        end
        ok = (acc_data.size() >= target);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pix_ready = 1'b0;
        hold_empty = 1'b0;
        fifo_data = '0;
        step();
        step();
        total++; if (fifo_rd !== 1'b0) begin bad++; $display("FAIL reset_fifo_rd got=%0b want=0", fifo_rd); end
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_pix_valid got=%0b want=0", pix_valid); end
        total++; if (pix_data !== 8'd0) begin bad++; $display("FAIL reset_pix_data got=%0d want=0", pix_data); end
        total++; if (pix_count !== 16'd0) begin bad++; $display("FAIL reset_pix_count got=%0d want=0", pix_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        rst = 1'b0;
        exp_count = 0;
    endtask

    task automatic test_white();
        bit ok;
        clear_logs();
        pix_ready = 1'b1;
        q.push_back(8'd255); q.push_back(8'd255); q.push_back(8'd255);
        drain(1, 40, ok);
        exp_count++;
        total++;
        if (!ok) begin
            bad++; $display("FAIL white_timeout got=%0d pixels want=1", acc_data.size());
        end else begin
            total++; if (acc_data[0] !== 8'd255) begin bad++; $display("FAIL white_data got=%0d want=255", acc_data[0]); end
            total++;
            if (vrise.size() < 1 || rd_cycles.size() < 1 || vrise[0] - rd_cycles[0] != 7) begin
                bad++; $display("FAIL white_latency got=%0d want=7",
                                (vrise.size() > 0 && rd_cycles.size() > 0) ? vrise[0] - rd_cycles[0] : -1);
            end
        end
        total++; if (pix_count !== 16'(exp_count)) begin bad++; $display("FAIL white_count got=%0d want=%0d", pix_count, exp_count); end
        step(); step(); step();
        total++; if (rd_cycles.size() != 3) begin bad++; $display("FAIL white_reads got=%0d want=3", rd_cycles.size()); end
    endtask

    task automatic test_vectors();
        logic [7:0] px[9];
        logic [7:0] want[3];
        bit ok;
        px = '{8'd100, 8'd50, 8'd200, 8'd1, 8'd1, 8'd0, 8'd255, 8'd0, 8'd0};
`ifdef GRAY_ROUND_EN
        want = '{8'd82, 8'd1, 8'd77};
`else
        want = '{8'd82, 8'd0, 8'd76};
`endif
        clear_logs();
        pix_ready = 1'b1;
        for (int i = 0; i < 9; i++) q.push_back(px[i]);
        drain(3, 80, ok);
        exp_count += 3;
        total++;
        if (!ok) begin
            bad++; $display("FAIL vectors_timeout got=%0d pixels want=3", acc_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (acc_data[i] !== want[i]) begin
                    bad++; $display("FAIL vectors_data[%0d] got=%0d want=%0d", i, acc_data[i], want[i]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                total++;
                if (acc_cyc[i+1] - acc_cyc[i] != 8) begin
                    bad++; $display("FAIL vectors_throughput[%0d] got=%0d want=8", i, acc_cyc[i+1] - acc_cyc[i]);
                end
            end
        end
        total++; if (pix_count !== 16'(exp_count)) begin bad++; $display("FAIL vectors_count got=%0d want=%0d", pix_count, exp_count); end
    endtask

    task automatic test_empty_stall();
        bit ok;
        clear_logs();
        pix_ready = 1'b1;
        q.push_back(8'd200);
        for (int i = 0; i < 5; i++) step();
        total++; if (rd_cycles.size() != 1) begin bad++; $display("FAIL stall_reads_while_empty got=%0d want=1", rd_cycles.size()); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%0b want=1", busy); end
        q.push_back(8'd100); q.push_back(8'd40);
        drain(1, 40, ok);
        exp_count++;
        total++;
        if (!ok) begin
            bad++; $display("FAIL stall_timeout got=%0d pixels want=1", acc_data.size());
        end else begin
            total++;
            if (acc_data[0] !== 8'(gray_ref(200, 100, 40))) begin
                bad++; $display("FAIL stall_data got=%0d want=%0d", acc_data[0], gray_ref(200, 100, 40));
            end
        end
        step(); step();
        total++; if (rd_cycles.size() != 3) begin bad++; $display("FAIL stall_reads got=%0d want=3", rd_cycles.size()); end
        total++; if (rd_empty_viol != 0) begin bad++; $display("FAIL stall_rd_empty got=%0d want=0", rd_empty_viol); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] hold_val;
        clear_logs();
        pix_ready = 1'b0;
        q.push_back(8'd30); q.push_back(8'd60); q.push_back(8'd90);
        q.push_back(8'd250); q.push_back(8'd10); q.push_back(8'd120);
        for (int i = 0; i < 30; i++) begin
            if (pix_valid === 1'b1) break;
            step();
        end
        total++;
        if (pix_valid !== 1'b1) begin
            bad++; $display("FAIL bp_valid_timeout got=%0b want=1", pix_valid);
        end
        hold_val = pix_data;
        for (int i = 0; i < 4; i++) step();
        total++; if (pix_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_hold got=%0b want=1", pix_valid); end
        total++; if (pix_data !== 8'(gray_ref(30, 60, 90)) || hold_val !== 8'(gray_ref(30, 60, 90))) begin
            bad++; $display("FAIL bp_data got=%0d/%0d want=%0d", hold_val, pix_data, gray_ref(30, 60, 90));
        end
        total++; if (stab_viol != 0) begin bad++; $display("FAIL bp_stability got=%0d want=0", stab_viol); end
        total++; if (rd_cycles.size() != 3) begin bad++; $display("FAIL bp_reads got=%0d want=3", rd_cycles.size()); end
        total++; if (pix_count !== 16'(exp_count)) begin bad++; $display("FAIL bp_count_hold got=%0d want=%0d", pix_count, exp_count); end
        pix_ready = 1'b1;
        step();
        exp_count++;
        total++; if (pix_count !== 16'(exp_count)) begin bad++; $display("FAIL bp_count_accept got=%0d want=%0d", pix_count, exp_count); end
        drain(2, 40, ok);
        exp_count++;
        total++;
        if (!ok) begin
            bad++; $display("FAIL bp_second_timeout got=%0d pixels want=2", acc_data.size());
        end else begin
            total++;
            if (acc_data[1] !== 8'(gray_ref(250, 10, 120))) begin
                bad++; $display("FAIL bp_second_data got=%0d want=%0d", acc_data[1], gray_ref(250, 10, 120));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        pix_ready = 1'b1;
        q.push_back(8'd7); q.push_back(8'd9);
        for (int i = 0; i < 20; i++) begin
            if (rd_cycles.size() >= 2) break;
            step();
        end
        step(); step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%0b want=1", busy); end
        rst = 1'b1;
        step();
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b want=0", pix_valid); end
        total++; if (pix_data !== 8'd0) begin bad++; $display("FAIL rstmid_data got=%0d want=0", pix_data); end
        total++; if (pix_count !== 16'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", pix_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
        rst = 1'b0;
        exp_count = 0;
        q.push_back(8'd10); q.push_back(8'd20); q.push_back(8'd30);
        drain(1, 40, ok);
        exp_count++;
        total++;
        if (!ok) begin
            bad++; $display("FAIL rstmid_timeout got=%0d pixels want=1", acc_data.size());
        end else begin
            total++;
            if (acc_data[0] !== 8'(gray_ref(10, 20, 30))) begin
                bad++; $display("FAIL rstmid_next_data got=%0d want=%0d", acc_data[0], gray_ref(10, 20, 30));
            end
        end
        total++; if (pix_count !== 16'(exp_count)) begin bad++; $display("FAIL rstmid_next_count got=%0d want=%0d", pix_count, exp_count); end
    endtask

    task automatic test_random();
        localparam int N = 20;
        logic [7:0] expq[$];
        int r, g, b;
        clear_logs();
        for (int i = 0; i < N; i++) begin
            r = int'($urandom_range(0, 255));
            g = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            q.push_back(8'(r)); q.push_back(8'(g)); q.push_back(8'(b));
            expq.push_back(8'(gray_ref(r, g, b)));
        end
        for (int i = 0; i < 2000; i++) begin
            if (acc_data.size() >= N) break;
            pix_ready  = ($urandom_range(0, 3) != 0);
            hold_empty = ($urandom_range(0, 4) == 0);
            step();
        end
        hold_empty = 1'b0;
        pix_ready  = 1'b1;
        exp_count += N;
        total++;
        if (acc_data.size() != N) begin
            bad++; $display("FAIL rand_timeout got=%0d pixels want=%0d", acc_data.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                total++;
                if (acc_data[i] !== expq[i]) begin
                    bad++; $display("FAIL rand_data[%0d] got=%0d want=%0d", i, acc_data[i], expq[i]);
                end
            end
        end
        total++; if (rd_cycles.size() != 3 * N) begin bad++; $display("FAIL rand_reads got=%0d want=%0d", rd_cycles.size(), 3 * N); end
        total++; if (rd_empty_viol != 0) begin bad++; $display("FAIL rand_rd_empty got=%0d want=0", rd_empty_viol); end
        total++; if (stab_viol != 0) begin bad++; $display("FAIL rand_stability got=%0d want=0", stab_viol); end
        total++; if (pix_count !== 16'(exp_count)) begin bad++; $display("FAIL rand_count got=%0d want=%0d", pix_count, exp_count); end
    endtask

    initial begin
        rst        = 1'b1;
        pix_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        @(negedge clk);
        test_reset();
        test_white();
        test_vectors();
        test_empty_stall();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
